cnn_frame_sequencer: RTL
========================

Name: cnn_frame_sequencer

Overview:
Frame-level controller for the MNIST CNN pipeline (conv1_layer -> maxpool_relu -> conv2_layer -> maxpool_relu -> fully_connected -> comparator). On a start request it clears the pipeline and streams one 784-pixel image from a pixel RAM into conv1 at one pixel per cycle. It then waits for the comparator decision and reports it, with timeout, label check and hit/frame statistics. It replaces bench-side pixel feeding and per-image reset pulsing.

Parameters:
IMG_PIXELS, 784, pixels per frame (28x28)
ADDR_BITS, 20, pixel RAM address width
CLR_CYCLES, 2, cycles cnn_rst_n is held low before streaming (>=1)
TIMEOUT, 4096, max cycles in DRAIN waiting for decision
STAT_BITS, 16, width of frame/hit counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin a frame (accepted only in IDLE)
img_base  in  ADDR_BITS  first pixel address, sampled with start
label  in  4  expected digit, sampled with start
abort  in  1  pulse; terminate current frame
clr_stats  in  1  pulse; zero frame_cnt/hit_cnt
pix_addr  out  ADDR_BITS  pixel RAM read address
pix_rd_en  out  1  pixel RAM read strobe
pix_rdata  in  8  RAM data, valid 1 cycle after pix_rd_en
cnn_rst_n  out  1  registered active-low reset to all CNN stages
data_in  out  8  pixel to conv1_layer
dec_valid  in  1  comparator valid_out
dec_in  in  4  comparator decision
busy  out  1  high in any state except IDLE
done  out  1  1-cycle pulse at frame end
decision  out  4  latched result (4'hF on timeout/abort)
match  out  1  decision==label, qualified by done
timeout  out  1  frame ended by timeout, qualified by done
frame_cnt  out  STAT_BITS  completed frames (incl. timeout, excl. abort)
hit_cnt  out  STAT_BITS  frames with match=1

Behaviour:
- Reset: state IDLE. cnn_rst_n=0, data_in=0, pix_rd_en=0, pix_addr=0, busy=0, done=0, decision=4'hF, match=0, timeout=0, frame_cnt=0, hit_cnt=0.
- States: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: cnn_rst_n=0. On start, latch img_base and label and go to CLEAR.
- CLEAR: cnn_rst_n=0 for exactly CLR_CYCLES cycles.
  - Last CLEAR cycle issues the read of img_base+0.
- Transition to STREAM at edge E: cnn_rst_n rises at E. data_in = pixel k from edge E+k (k=0..783), so conv1 samples pixel 0 at E+1.
- Reads: pixel k is read at address img_base+k.
  - The read is issued one cycle before data_in needs it.
  - The last read is issued at k=783.
- After pixel 783 is loaded, data_in is driven to 0 and go to DRAIN. conv1 has no valid; zeros pad the drain.
- DRAIN:
  - Count cycles from 0.
  - On dec_valid: decision<=dec_in, match<=(dec_in==label), timeout<=0, go to DONE.
  - If the count reaches TIMEOUT-1 without dec_valid: decision<=4'hF, match<=0, timeout<=1, go to DONE.
  - dec_valid and timeout on the same cycle: dec_valid wins.
- dec_valid outside DRAIN is ignored.
- DONE (1 cycle):
  - done=1, cnn_rst_n=0.
  - frame_cnt+=1; hit_cnt+=match.
  - Both counters saturate at all-ones.
  - Then go to IDLE.
- start outside IDLE is ignored; start is never queued. A start asserted in the DONE cycle is ignored.
- abort in CLEAR/STREAM/DRAIN:
  - Next state IDLE; cnn_rst_n=0 and data_in=0 next cycle.
  - No done pulse, counters unchanged, decision<=4'hF.
  - abort in IDLE or DONE has no effect.
  - abort beats dec_valid on the same cycle.
- clr_stats zeroes both counters. It takes priority over a DONE increment in the same cycle.
- Address arithmetic is modulo 2^ADDR_BITS (wraps silently).
- Pixel index counter is ceil(log2(IMG_PIXELS+1)) bits.

Decomposition:
- Shared package cnn_pkg:
  - state encoding (IDLE/CLEAR/STREAM/DRAIN/DONE)
  - IMG_PIXELS=784
  - DECISION_NONE=4'hF
  - a clog2 function
- One natural sub-module: cnn_frame_stats (frame_cnt/hit_cnt, saturation, clr_stats priority).
- FSM, address generation and timeout counter stay in the top.

Test Plan:
- Ramp RAM (pixel k = k[7:0]), img_base=0, start -> cnn_rst_n low exactly 2 cycles; data_in = 0,1,...,255,0,... over 784 cycles; then data_in=0; pix_addr 0..783 once each.
- img_base=784, label=7, model dec_valid=1 with dec_in=7 after 300 DRAIN cycles -> done pulse, decision=7, match=1, frame_cnt=1, hit_cnt=1.
- No dec_valid -> done exactly TIMEOUT cycles after DRAIN entry; decision=4'hF, timeout=1, frame_cnt incremented, hit_cnt not.
- abort at pixel 400 -> IDLE next cycle, no done, cnn_rst_n=0, counters unchanged; a following start restreams from pixel 0.
- start held high through busy, plus dec_valid during STREAM -> only one frame runs and the spurious valid is ignored. clr_stats coincident with DONE -> counters read 0.
- Assert rst_n low mid-STREAM (asynchronous, between edges) -> all outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN frame sequencer: FSM encoding, frame geometry
// and a constant-width helper.
package cnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int         IMG_PIXELS    = 784;
  localparam logic [3:0] DECISION_NONE = 4'hF;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cnn_frame_stats.sv
// Saturating completed-frame and hit counters; a clear beats a same-cycle increment.
module cnn_frame_stats #(
  parameter int STAT_BITS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_inc,
  input  logic                 i_hit,
  output logic [STAT_BITS-1:0] o_frame_cnt,
  output logic [STAT_BITS-1:0] o_hit_cnt
);

  localparam logic [STAT_BITS-1:0] CNT_MAX = '1;
  localparam logic [STAT_BITS-1:0] CNT_ONE = STAT_BITS'(1);

  logic [STAT_BITS-1:0] r_frame_cnt;
  logic [STAT_BITS-1:0] r_hit_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= '0;
      r_hit_cnt   <= '0;
    end else if (i_clr) begin
      r_frame_cnt <= '0;
      r_hit_cnt   <= '0;
    end else if (i_inc) begin
      if (r_frame_cnt != CNT_MAX)          r_frame_cnt <= r_frame_cnt + CNT_ONE;
      if (i_hit && (r_hit_cnt != CNT_MAX)) r_hit_cnt   <= r_hit_cnt + CNT_ONE;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_hit_cnt   = r_hit_cnt;

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame controller: clears the CNN, streams one image from pixel RAM into conv1,
// then waits (with timeout) for the comparator decision and reports it.
module cnn_frame_sequencer
  import cnn_pkg::*;
#(
  parameter int IMG_PIXELS = cnn_pkg::IMG_PIXELS,
  parameter int ADDR_BITS  = 20,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 4096,
  parameter int STAT_BITS  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [ADDR_BITS-1:0] i_img_base,
  input  logic [3:0]           i_label,
  input  logic                 i_abort,
  input  logic                 i_clr_stats,
  output logic [ADDR_BITS-1:0] o_pix_addr,
  output logic                 o_pix_rd_en,
  input  logic [7:0]           i_pix_rdata,
  output logic                 o_cnn_rst_n,
  output logic [7:0]           o_data_in,
  input  logic                 i_dec_valid,
  input  logic [3:0]           i_dec_in,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [3:0]           o_decision,
  output logic                 o_match,
  output logic                 o_timeout,
  output logic [STAT_BITS-1:0] o_frame_cnt,
  output logic [STAT_BITS-1:0] o_hit_cnt
);

  localparam int PIX_W = clog2(IMG_PIXELS + 1);
  localparam int TO_W  = (TIMEOUT > 1)    ? clog2(TIMEOUT)    : 1;
  localparam int CLR_W = (CLR_CYCLES > 1) ? clog2(CLR_CYCLES) : 1;

  localparam logic [PIX_W-1:0]     LAST_PIX = PIX_W'(IMG_PIXELS - 1);
  localparam logic [PIX_W-1:0]     LAST_RD  = PIX_W'(IMG_PIXELS - 2);
  localparam logic [PIX_W-1:0]     PIX_ONE  = PIX_W'(1);
  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]      TO_ONE   = TO_W'(1);
  localparam logic [CLR_W-1:0]     CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [CLR_W-1:0]     CLR_ONE  = CLR_W'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  state_e               r_state;
  logic [ADDR_BITS-1:0] r_base;
  logic [3:0]           r_label;
  logic [ADDR_BITS-1:0] r_pix_addr;
  logic                 r_rd_en;
  logic                 r_cnn_rst_n;
  logic [PIX_W-1:0]     r_pix_idx;
  logic [CLR_W-1:0]     r_clr_cnt;
  logic [TO_W-1:0]      r_drain_cnt;
  logic                 r_done;
  logic [3:0]           r_decision;
  logic                 r_match;
  logic                 r_timeout;

  logic [CLR_W-1:0]     w_clr_next;
  logic                 w_abort;

  assign w_clr_next = r_clr_cnt + CLR_ONE;
  assign w_abort    = i_abort && (r_state inside {ST_CLEAR, ST_STREAM, ST_DRAIN});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_label     <= '0;
      r_pix_addr  <= '0;
      r_rd_en     <= 1'b0;
      r_cnn_rst_n <= 1'b0;
      r_pix_idx   <= '0;
      r_clr_cnt   <= '0;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
      r_decision  <= DECISION_NONE;
      r_match     <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (w_abort) begin
      r_state     <= ST_IDLE;
      r_rd_en     <= 1'b0;
      r_cnn_rst_n <= 1'b0;
      r_decision  <= DECISION_NONE;
      r_match     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnn_rst_n <= 1'b0;
          if (i_start) begin
            r_base    <= i_img_base;
            r_label   <= i_label;
            r_clr_cnt <= '0;
            r_state   <= ST_CLEAR;
            if (CLR_CYCLES == 1) begin
              r_rd_en    <= 1'b1;
              r_pix_addr <= i_img_base;
            end
          end
        end
        ST_CLEAR: begin
          r_clr_cnt <= w_clr_next;
          // Pixel 0 is fetched during the final clear cycle so it lands as streaming begins.
          if (w_clr_next == CLR_LAST) begin
            r_rd_en    <= 1'b1;
            r_pix_addr <= r_base;
          end
          if (r_clr_cnt == CLR_LAST) begin
            r_state     <= ST_STREAM;
            r_cnn_rst_n <= 1'b1;
            r_pix_idx   <= '0;
            r_rd_en     <= 1'b1;
            r_pix_addr  <= r_pix_addr + ADDR_ONE;
          end
        end
        ST_STREAM: begin
          if (r_pix_idx == LAST_PIX) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
            r_rd_en     <= 1'b0;
          end else begin
            r_pix_idx <= r_pix_idx + PIX_ONE;
            r_rd_en   <= (r_pix_idx < LAST_RD);
            if (r_pix_idx < LAST_RD) r_pix_addr <= r_pix_addr + ADDR_ONE;
          end
        end
        ST_DRAIN: begin
          if (i_dec_valid) begin
            r_decision  <= i_dec_in;
            r_match     <= (i_dec_in == r_label);
            r_timeout   <= 1'b0;
            r_done      <= 1'b1;
            r_cnn_rst_n <= 1'b0;
            r_state     <= ST_DONE;
          end else if (r_drain_cnt == TO_LAST) begin
            r_decision  <= DECISION_NONE;
            r_match     <= 1'b0;
            r_timeout   <= 1'b1;
            r_done      <= 1'b1;
            r_cnn_rst_n <= 1'b0;
            r_state     <= ST_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + TO_ONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  cnn_frame_stats #(.STAT_BITS(STAT_BITS)) u_stats (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (i_clr_stats),
    .i_inc       (r_state == ST_DONE),
    .i_hit       (r_match),
    .o_frame_cnt (o_frame_cnt),
    .o_hit_cnt   (o_hit_cnt)
  );

  // RAM data is already one cycle behind the address, so it feeds conv1 directly.
  assign o_data_in   = (r_state == ST_STREAM) ? i_pix_rdata : 8'h00;
  assign o_pix_addr  = r_pix_addr;
  assign o_pix_rd_en = r_rd_en;
  assign o_cnn_rst_n = r_cnn_rst_n;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = r_done;
  assign o_decision  = r_decision;
  assign o_match     = r_match;
  assign o_timeout   = r_timeout;

endmodule
